// File: rtl/zwait_pkg.sv
// ---------------------------------------------------------------------------
// zwait_pkg -- shared definitions for the Z80 wait-state service block.
//   * zwait_cmd_e   : command codes issued from the SPI/MCU side
//   * zwait_state_e : FSM state encoding of zwait_svc
//   * ZW_IDLE_BYTE  : value driven to the Z80 when no data has been supplied
//   * zw_stat_byte  : builds the GETSTAT response byte
// Optional feature macro (used by zwait_svc): ZWAIT_TIMEOUT_EN
// ---------------------------------------------------------------------------
package zwait_pkg;

   typedef enum logic [1:0] {
      CMD_GETSTAT = 2'd0,
      CMD_GETDATA = 2'd1,
      CMD_SETDATA = 2'd2,
      CMD_RELEASE = 2'd3
   } zwait_cmd_e;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_CAPT = 3'd1,
      ST_SERV = 3'd2,
      ST_REL  = 3'd3,
      ST_HOLD = 3'd4
   } zwait_state_e;

   localparam logic [7:0] ZW_IDLE_BYTE = 8'hFF;

   // Status byte layout: {4'b0, timed_out, wrn, status[1:0]}
   function automatic logic [7:0] zw_stat_byte(input logic       tmo,
                                                input logic       wrn,
                                                input logic [1:0] status);
      return {4'b0000, tmo, wrn, status};
   endfunction

endpackage

// File: rtl/zwait_tmo.sv
// ---------------------------------------------------------------------------
// zwait_tmo -- service timeout counter for zwait_svc (only instantiated when
// ZWAIT_TIMEOUT_EN is defined).
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : clear the count (asserted the cycle before SERV is entered)
//   inc        : count this cycle (asserted in every SERV cycle)
//   hit        : the count reaches 2^TMO_W-1 on the coming edge
// ---------------------------------------------------------------------------
module zwait_tmo #(
   parameter int TMO_W = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic inc,
   output logic hit
);

   // Last value before the all-ones terminal count; seeing it while counting
   // means the increment on this edge reaches the terminal value.
   localparam logic [TMO_W-1:0] CNT_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

   logic [TMO_W-1:0] cnt_r;

   // Count SERV cycles, restarting on every capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r <= {TMO_W{1'b0}};
      end else if (clr) begin
         cnt_r <= {TMO_W{1'b0}};
      end else if (inc) begin
         cnt_r <= cnt_r + {{(TMO_W-1){1'b0}}, 1'b1};
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign hit = inc && (cnt_r == CNT_LAST);

endmodule

// File: rtl/zwait_svc.sv
// ---------------------------------------------------------------------------
// zwait_svc -- services Z80/DMA wait states on behalf of an SPI-attached MCU.
// A pending wait (spiint_n low) is captured, flagged via svc_irq, and served
// by commands: GETSTAT / GETDATA / SETDATA / RELEASE. RELEASE emits one
// wait_end pulse, after which the block holds off until spiint_n returns high.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   spiint_n          : low while a wait is pending
//   wait_status[1:0]  : wait source code, latched on capture
//   wait_status_wrn   : 0 = Z80 write, 1 = Z80 read, latched on capture
//   zdata_in[7:0]     : Z80 data bus, latched on capture
//   cmd_stb, cmd[1:0] : one-cycle command strobe and command code
//   cmd_wdata[7:0]    : SETDATA operand
//   rsp_data, rsp_valid : response byte and its one-cycle qualifier
//   wait_rdata[7:0]   : byte returned to the Z80 on read waits
//   wait_end          : one-cycle pulse terminating the wait
//   svc_irq           : high while in SERV
//   cmd_err           : sticky illegal-command flag, cleared by GETSTAT
// Build option: define ZWAIT_TIMEOUT_EN to release an unserved wait after
// 2^TMO_W-1 SERV cycles (wait_rdata forced to 8'hFF, timed_out set).
// ---------------------------------------------------------------------------
module zwait_svc
   import zwait_pkg::*;
#(
   parameter int TMO_W = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       spiint_n,
   input  logic [1:0] wait_status,
   input  logic       wait_status_wrn,
   input  logic [7:0] zdata_in,
   input  logic       cmd_stb,
   input  logic [1:0] cmd,
   input  logic [7:0] cmd_wdata,
   output logic [7:0] rsp_data,
   output logic       rsp_valid,
   output logic [7:0] wait_rdata,
   output logic       wait_end,
   output logic       svc_irq,
   output logic       cmd_err
);

   zwait_state_e state_r;
   logic [1:0]   status_r;
   logic         wrn_r;
   logic [7:0]   zdata_r;
   logic         hold_cnt_r;
   logic [7:0]   rsp_data_r;
   logic         rsp_valid_r;
   logic [7:0]   wait_rdata_r;
   logic         wait_end_r;
   logic         svc_irq_r;
   logic         cmd_err_r;

   logic         timed_out_s;
   logic         tmo_hit_s;
   logic         in_serv_s;

   assign in_serv_s = (state_r == ST_SERV);

`ifdef ZWAIT_TIMEOUT_EN
   logic timed_out_r;

   zwait_tmo #(
      .TMO_W (TMO_W)
   ) u_tmo (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (state_r == ST_CAPT),
      .inc   (in_serv_s),
      .hit   (tmo_hit_s)
   );

   // Timeout flag: set when SERV expires, cleared by the next capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         timed_out_r <= 1'b0;
      end else if (state_r == ST_CAPT) begin
         timed_out_r <= 1'b0;
      end else if (tmo_hit_s) begin
         timed_out_r <= 1'b1;
      end else begin
         timed_out_r <= timed_out_r;
      end
   end

   assign timed_out_s = timed_out_r;
`else
   assign timed_out_s = 1'b0;
   assign tmo_hit_s   = 1'b0;
`endif

   // Main FSM with command decode and all registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= ST_IDLE;
         status_r     <= 2'b00;
         wrn_r        <= 1'b0;
         zdata_r      <= 8'h00;
         hold_cnt_r   <= 1'b0;
         rsp_data_r   <= 8'h00;
         rsp_valid_r  <= 1'b0;
         wait_rdata_r <= ZW_IDLE_BYTE;
         wait_end_r   <= 1'b0;
         svc_irq_r    <= 1'b0;
         cmd_err_r    <= 1'b0;
      end else begin
         rsp_valid_r <= 1'b0;
         wait_end_r  <= 1'b0;

         // Commands are judged against the current state, so a strobe in the
         // IDLE->CAPT cycle still counts as outside SERV.
         if (cmd_stb) begin
            case (zwait_cmd_e'(cmd))
               CMD_GETSTAT: begin
                  rsp_data_r  <= zw_stat_byte(timed_out_s, wrn_r, status_r);
                  rsp_valid_r <= 1'b1;
                  cmd_err_r   <= 1'b0;
               end
               CMD_GETDATA: begin
                  rsp_valid_r <= 1'b1;
                  if (in_serv_s) begin
                     rsp_data_r <= zdata_r;
                  end else begin
                     rsp_data_r <= ZW_IDLE_BYTE;
                     cmd_err_r  <= 1'b1;
                  end
               end
               CMD_SETDATA: begin
                  if (in_serv_s) begin
                     wait_rdata_r <= cmd_wdata;
                  end else begin
                     cmd_err_r <= 1'b1;
                  end
               end
               CMD_RELEASE: begin
                  if (!in_serv_s) begin
                     cmd_err_r <= 1'b1;
                  end
               end
               default: begin
                  cmd_err_r <= 1'b1;
               end
            endcase
         end

         case (state_r)
            ST_IDLE: begin
               if (!spiint_n) begin
                  state_r <= ST_CAPT;
               end
            end
            ST_CAPT: begin
               status_r  <= wait_status;
               wrn_r     <= wait_status_wrn;
               zdata_r   <= zdata_in;
               state_r   <= ST_SERV;
               svc_irq_r <= 1'b1;
            end
            ST_SERV: begin
               // Timeout overrides any SETDATA landing in the same cycle
               if (tmo_hit_s) begin
                  wait_rdata_r <= ZW_IDLE_BYTE;
                  state_r      <= ST_REL;
                  svc_irq_r    <= 1'b0;
                  wait_end_r   <= 1'b1;
               end else if (cmd_stb && (zwait_cmd_e'(cmd) == CMD_RELEASE)) begin
                  state_r    <= ST_REL;
                  svc_irq_r  <= 1'b0;
                  wait_end_r <= 1'b1;
               end
            end
            ST_REL: begin
               state_r    <= ST_HOLD;
               hold_cnt_r <= 1'b0;
            end
            ST_HOLD: begin
               // Two-cycle minimum lets the wait generator drop spiint_n
               // before a low level can be mistaken for a new request.
               if (!hold_cnt_r) begin
                  hold_cnt_r <= 1'b1;
               end else if (spiint_n) begin
                  state_r <= ST_IDLE;
               end
            end
            default: begin
               state_r   <= ST_IDLE;
               svc_irq_r <= 1'b0;
            end
         endcase
      end
   end

   assign rsp_data   = rsp_data_r;
   assign rsp_valid  = rsp_valid_r;
   assign wait_rdata = wait_rdata_r;
   assign wait_end   = wait_end_r;
   assign svc_irq    = svc_irq_r;
   assign cmd_err    = cmd_err_r;

endmodule

// File: tb/tb_zwait_svc.sv
// ---------------------------------------------------------------------------
// tb_zwait_svc -- self-checking bench for zwait_svc. Expected response bytes
// are queued when a command is issued and popped when rsp_valid appears.
// Define ZWAIT_TIMEOUT_EN to also exercise the timeout (TMO_W = 4).
// ---------------------------------------------------------------------------
module tb_zwait_svc;

`ifdef ZWAIT_TIMEOUT_EN
   localparam int TW = 4;
`else
   localparam int TW = 16;
`endif

   localparam logic [1:0] C_GETSTAT = 2'd0;
   localparam logic [1:0] C_GETDATA = 2'd1;
   localparam logic [1:0] C_SETDATA = 2'd2;
   localparam logic [1:0] C_RELEASE = 2'd3;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       spiint_n;
   logic [1:0] wait_status;
   logic       wait_status_wrn;
   logic [7:0] zdata_in;
   logic       cmd_stb;
   logic [1:0] cmd;
   logic [7:0] cmd_wdata;
   logic [7:0] rsp_data;
   logic       rsp_valid;
   logic [7:0] wait_rdata;
   logic       wait_end;
   logic       svc_irq;
   logic       cmd_err;

   int         n_checks = 0;
   int         n_errors = 0;
   int         we_cnt   = 0;
   logic [7:0] exp_q[$];
   logic [7:0] exp_d;

   zwait_svc #(.TMO_W(TW)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .spiint_n        (spiint_n),
      .wait_status     (wait_status),
      .wait_status_wrn (wait_status_wrn),
      .zdata_in        (zdata_in),
      .cmd_stb         (cmd_stb),
      .cmd             (cmd),
      .cmd_wdata       (cmd_wdata),
      .rsp_data        (rsp_data),
      .rsp_valid       (rsp_valid),
      .wait_rdata      (wait_rdata),
      .wait_end        (wait_end),
      .svc_irq         (svc_irq),
      .cmd_err         (cmd_err)
   );

   always #5 clk = ~clk;

   // count wait_end pulses (one per high sample)
   always @(negedge clk) begin
      if (wait_end === 1'b1) we_cnt <= we_cnt + 1;
   end

   // global time limit
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // all drive tasks start and end at a negedge
   task automatic cmd_pulse(input logic [1:0] c, input logic [7:0] wd);
      cmd = c; cmd_wdata = wd; cmd_stb = 1'b1;
      @(negedge clk);
      cmd_stb = 1'b0;
   endtask

   task automatic start_wait(input logic [1:0] st, input logic wrn, input logic [7:0] d);
      wait_status = st; wait_status_wrn = wrn; zdata_in = d; spiint_n = 1'b0;
      @(negedge clk);   // IDLE -> CAPT
      @(negedge clk);   // CAPT -> SERV
   endtask

   task automatic end_wait();
      spiint_n = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      n_checks++; if (rsp_data !== 8'h00)   begin n_errors++; $display("FAIL rst_rsp_data: got %h want 00", rsp_data); end
      n_checks++; if (rsp_valid !== 1'b0)   begin n_errors++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
      n_checks++; if (wait_rdata !== 8'hFF) begin n_errors++; $display("FAIL rst_wait_rdata: got %h want FF", wait_rdata); end
      n_checks++; if (wait_end !== 1'b0)    begin n_errors++; $display("FAIL rst_wait_end: got %b want 0", wait_end); end
      n_checks++; if (svc_irq !== 1'b0)     begin n_errors++; $display("FAIL rst_svc_irq: got %b want 0", svc_irq); end
      n_checks++; if (cmd_err !== 1'b0)     begin n_errors++; $display("FAIL rst_cmd_err: got %b want 0", cmd_err); end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_illegal_idle();
      int w0;
      w0 = we_cnt;
      cmd_pulse(C_RELEASE, 8'h00);
      n_checks++; if (rsp_valid !== 1'b0) begin n_errors++; $display("FAIL idle_release_rsp: got valid %b want 0", rsp_valid); end
      n_checks++; if (cmd_err !== 1'b1)   begin n_errors++; $display("FAIL idle_release_err: got %b want 1", cmd_err); end
      repeat (2) @(negedge clk);
      n_checks++; if (we_cnt !== w0)      begin n_errors++; $display("FAIL idle_release_wait_end: got %0d pulses want 0", we_cnt - w0); end
      exp_q.push_back(8'hFF);
      cmd_pulse(C_GETDATA, 8'h00);
      exp_d = exp_q.pop_front();
      n_checks++; if (rsp_valid !== 1'b1 || rsp_data !== exp_d) begin n_errors++; $display("FAIL idle_getdata: got valid %b data %h want 1 %h", rsp_valid, rsp_data, exp_d); end
      cmd_pulse(C_SETDATA, 8'h11);
      n_checks++; if (wait_rdata !== 8'hFF) begin n_errors++; $display("FAIL idle_setdata: got %h want FF", wait_rdata); end
      exp_q.push_back(8'h00);
      cmd_pulse(C_GETSTAT, 8'h00);
      exp_d = exp_q.pop_front();
      n_checks++; if (rsp_valid !== 1'b1 || rsp_data !== exp_d) begin n_errors++; $display("FAIL idle_getstat: got valid %b data %h want 1 %h", rsp_valid, rsp_data, exp_d); end
      n_checks++; if (cmd_err !== 1'b0) begin n_errors++; $display("FAIL getstat_clears_err: got %b want 0", cmd_err); end
   endtask

   task automatic test_read_wait();
      int w0;
      start_wait(2'b01, 1'b1, 8'h99);
      n_checks++; if (svc_irq !== 1'b1) begin n_errors++; $display("FAIL rd_svc_irq: got %b want 1", svc_irq); end
      w0 = we_cnt;
      cmd_pulse(C_SETDATA, 8'h5A);
      n_checks++; if (wait_rdata !== 8'h5A || rsp_valid !== 1'b0) begin n_errors++; $display("FAIL rd_setdata: got rdata %h valid %b want 5A 0", wait_rdata, rsp_valid); end
      exp_q.push_back(8'h05);
      cmd_pulse(C_GETSTAT, 8'h00);
      exp_d = exp_q.pop_front();
      n_checks++; if (rsp_valid !== 1'b1 || rsp_data !== exp_d) begin n_errors++; $display("FAIL rd_getstat: got valid %b data %h want 1 %h", rsp_valid, rsp_data, exp_d); end
      cmd_pulse(C_RELEASE, 8'h00);
      n_checks++; if (wait_end !== 1'b1 || svc_irq !== 1'b0) begin n_errors++; $display("FAIL rd_release: got wait_end %b svc_irq %b want 1 0", wait_end, svc_irq); end
      end_wait();
      n_checks++; if (we_cnt - w0 !== 1) begin n_errors++; $display("FAIL rd_wait_end_count: got %0d want 1", we_cnt - w0); end
      n_checks++; if (wait_rdata !== 8'h5A) begin n_errors++; $display("FAIL rd_rdata_after: got %h want 5A", wait_rdata); end
   endtask

   task automatic test_write_wait();
      start_wait(2'b10, 1'b0, 8'hC3);
      exp_q.push_back(8'hC3);
      cmd_pulse(C_GETDATA, 8'h00);
      exp_d = exp_q.pop_front();
      n_checks++; if (rsp_valid !== 1'b1 || rsp_data !== exp_d) begin n_errors++; $display("FAIL wr_getdata: got valid %b data %h want 1 %h", rsp_valid, rsp_data, exp_d); end
      exp_q.push_back(8'h02);
      cmd_pulse(C_GETSTAT, 8'h00);
      exp_d = exp_q.pop_front();
      n_checks++; if (rsp_valid !== 1'b1 || rsp_data !== exp_d) begin n_errors++; $display("FAIL wr_getstat: got valid %b data %h want 1 %h", rsp_valid, rsp_data, exp_d); end
      n_checks++; if (wait_rdata !== 8'h5A) begin n_errors++; $display("FAIL wr_rdata_held: got %h want 5A", wait_rdata); end
      cmd_pulse(C_RELEASE, 8'h00);
      n_checks++; if (wait_end !== 1'b1) begin n_errors++; $display("FAIL wr_release: got wait_end %b want 1", wait_end); end
      end_wait();
   endtask

   task automatic test_hold_no_recapture();
      int w0;
      int irq_hi;
      start_wait(2'b11, 1'b1, 8'h00);
      w0 = we_cnt;
      cmd_pulse(C_RELEASE, 8'h00);
      @(negedge clk);            // spiint_n still low one cycle after release
      spiint_n = 1'b1;
      irq_hi = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (svc_irq === 1'b1) irq_hi++;
      end
      n_checks++; if (irq_hi !== 0) begin n_errors++; $display("FAIL hold_recapture: got %0d irq cycles want 0", irq_hi); end
      n_checks++; if (we_cnt - w0 !== 1) begin n_errors++; $display("FAIL hold_wait_end_count: got %0d want 1", we_cnt - w0); end
   endtask

   task automatic test_capt_cmd_same_cycle();
      wait_status = 2'b01; wait_status_wrn = 1'b1; zdata_in = 8'h77; spiint_n = 1'b0;
      exp_q.push_back(8'hFF);
      cmd_pulse(C_GETDATA, 8'h00);   // strobe coincides with IDLE -> CAPT
      exp_d = exp_q.pop_front();
      n_checks++; if (rsp_valid !== 1'b1 || rsp_data !== exp_d) begin n_errors++; $display("FAIL capt_getdata: got valid %b data %h want 1 %h", rsp_valid, rsp_data, exp_d); end
      n_checks++; if (cmd_err !== 1'b1) begin n_errors++; $display("FAIL capt_cmd_err: got %b want 1", cmd_err); end
      @(negedge clk);
      n_checks++; if (svc_irq !== 1'b1) begin n_errors++; $display("FAIL capt_svc_irq: got %b want 1", svc_irq); end
      exp_q.push_back(8'h05);
      cmd_pulse(C_GETSTAT, 8'h00);
      exp_d = exp_q.pop_front();
      n_checks++; if (rsp_valid !== 1'b1 || rsp_data !== exp_d || cmd_err !== 1'b0) begin n_errors++; $display("FAIL capt_getstat: got valid %b data %h err %b want 1 %h 0", rsp_valid, rsp_data, cmd_err, exp_d); end
      cmd_pulse(C_RELEASE, 8'h00);
      end_wait();
   endtask

   task automatic test_reset_in_serv();
      int w0;
      start_wait(2'b01, 1'b0, 8'hAA);
      cmd_pulse(C_SETDATA, 8'h3C);
      w0 = we_cnt;
      rst_n = 1'b0;
      #1;
      n_checks++; if (svc_irq !== 1'b0 || wait_end !== 1'b0) begin n_errors++; $display("FAIL rsts_immediate: got svc_irq %b wait_end %b want 0 0", svc_irq, wait_end); end
      spiint_n = 1'b1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      n_checks++; if (we_cnt !== w0) begin n_errors++; $display("FAIL rsts_wait_end: got %0d pulses want 0", we_cnt - w0); end
      n_checks++; if (wait_rdata !== 8'hFF) begin n_errors++; $display("FAIL rsts_rdata: got %h want FF", wait_rdata); end
      exp_q.push_back(8'hFF);
      cmd_pulse(C_GETDATA, 8'h00);
      exp_d = exp_q.pop_front();
      n_checks++; if (rsp_valid !== 1'b1 || rsp_data !== exp_d || cmd_err !== 1'b1) begin n_errors++; $display("FAIL rsts_idle: got valid %b data %h err %b want 1 %h 1", rsp_valid, rsp_data, cmd_err, exp_d); end
      exp_q.push_back(8'h00);
      cmd_pulse(C_GETSTAT, 8'h00);
      exp_d = exp_q.pop_front();
      n_checks++; if (rsp_valid !== 1'b1 || rsp_data !== exp_d) begin n_errors++; $display("FAIL rsts_getstat: got valid %b data %h want 1 %h", rsp_valid, rsp_data, exp_d); end
   endtask

`ifdef ZWAIT_TIMEOUT_EN
   task automatic test_timeout();
      int irq_cycles;
      bit seen;
      start_wait(2'b10, 1'b1, 8'h00);
      cmd_pulse(C_SETDATA, 8'h42);
      irq_cycles = 1;            // SERV cycle consumed by SETDATA
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         if (wait_end === 1'b1) seen = 1'b1;
         else begin
            if (svc_irq === 1'b1) irq_cycles++;
            @(negedge clk);
         end
      end
      n_checks++; if (!seen || irq_cycles !== 15) begin n_errors++; $display("FAIL tmo_expiry: got seen %b serv cycles %0d want 1 15", seen, irq_cycles); end
      n_checks++; if (wait_rdata !== 8'hFF) begin n_errors++; $display("FAIL tmo_rdata: got %h want FF", wait_rdata); end
      exp_q.push_back(8'h16);
      cmd_pulse(C_GETSTAT, 8'h00);
      exp_d = exp_q.pop_front();
      n_checks++; if (rsp_valid !== 1'b1 || rsp_data !== exp_d) begin n_errors++; $display("FAIL tmo_getstat: got valid %b data %h want 1 %h", rsp_valid, rsp_data, exp_d); end
      end_wait();
      start_wait(2'b01, 1'b0, 8'h00);
      exp_q.push_back(8'h01);
      cmd_pulse(C_GETSTAT, 8'h00);
      exp_d = exp_q.pop_front();
      n_checks++; if (rsp_valid !== 1'b1 || rsp_data !== exp_d) begin n_errors++; $display("FAIL tmo_cleared: got valid %b data %h want 1 %h", rsp_valid, rsp_data, exp_d); end
      cmd_pulse(C_RELEASE, 8'h00);
      end_wait();
   endtask
`endif

   initial begin
      rst_n = 1'b0; spiint_n = 1'b1; wait_status = 2'b00; wait_status_wrn = 1'b0;
      zdata_in = 8'h00; cmd_stb = 1'b0; cmd = 2'b00; cmd_wdata = 8'h00;
      test_reset();
      test_illegal_idle();
      test_read_wait();
      test_write_wait();
      test_hold_no_recapture();
      test_capt_cmd_same_cycle();
      test_reset_in_serv();
`ifdef ZWAIT_TIMEOUT_EN
      test_timeout();
`endif
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/zwait_svc.md
ZWAIT_SVC -- requirements
Module: zwait_svc

Interface
REQ-001 SHALL have parameter TMO_W, default 16, timeout counter width in bits.
REQ-002 SHALL have port clk, input, 1, single system clock; all logic on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port spiint_n, input, 1, low while a Z80 or DMA wait is pending.
REQ-005 SHALL have port wait_status, input, 2, pending wait source code.
REQ-006 SHALL have port wait_status_wrn, input, 1, 0 = Z80 write access, 1 = read access.
REQ-007 SHALL have port zdata_in, input, 8, Z80 data bus as seen during the wait.
REQ-008 SHALL have port cmd_stb, input, 1, one-cycle command strobe from the SPI/MCU side.
REQ-009 SHALL have port cmd, input, 2, command code: 0 GETSTAT, 1 GETDATA, 2 SETDATA, 3 RELEASE.
REQ-010 SHALL have port cmd_wdata, input, 8, operand for SETDATA.
REQ-011 SHALL have port rsp_data, output, 8, command response byte.
REQ-012 SHALL have port rsp_valid, output, 1, one-cycle pulse qualifying rsp_data.
REQ-013 SHALL have port wait_rdata, output, 8, byte returned to the Z80 on read waits.
REQ-014 SHALL have port wait_end, output, 1, one-cycle pulse that ends the wait.
REQ-015 SHALL have port svc_irq, output, 1, high while a captured request awaits service.
REQ-016 SHALL have port cmd_err, output, 1, sticky illegal-command flag.

Function
- REQ-017 SHALL implement FSM states IDLE, CAPT, SERV, REL and HOLD.
- REQ-018 IDLE -> CAPT SHALL occur on the first cycle spiint_n is sampled low.
- REQ-019 CAPT SHALL latch wait_status, wait_status_wrn and zdata_in in that one cycle, then go to SERV.
- REQ-020 svc_irq SHALL be high exactly while in SERV.
- REQ-021 GETSTAT SHALL return {4'b0, timed_out, wrn_latched, status_latched[1:0]} with rsp_valid one cycle after cmd_stb, in any state.
- REQ-022 GETDATA in SERV SHALL return the latched zdata_in with the same one-cycle latency.
- REQ-023 SETDATA in SERV SHALL load wait_rdata from cmd_wdata on the next edge; it SHALL produce no rsp_valid.
- REQ-024 RELEASE in SERV SHALL go to REL; REL SHALL assert wait_end for exactly one cycle, then go to HOLD.
- REQ-025 HOLD SHALL last at least 2 cycles and until spiint_n is sampled high, then go to IDLE; a re-assertion is never taken as a new request before IDLE.
- REQ-026 GETDATA, SETDATA or RELEASE outside SERV SHALL be ignored, SHALL set cmd_err, and SHALL return rsp_valid with rsp_data 8'hFF for GETDATA.
- REQ-027 cmd_err SHALL clear only by reset or a GETSTAT response (read-to-clear).
- REQ-028 A cmd_stb in the same cycle as the IDLE->CAPT transition SHALL be evaluated against IDLE.
- REQ-029 wait_rdata SHALL hold its value across requests until the next SETDATA.

Reset
- REQ-030 Asserting rst_n low SHALL, at any time and in any state, force IDLE and clear all latches, counters and cmd_err.
- REQ-031 During and after reset, until the next event: rsp_data 0, rsp_valid 0, wait_rdata 8'hFF, wait_end 0, svc_irq 0, cmd_err 0.
- REQ-032 A reset in SERV SHALL emit no wait_end; the wait generator clears itself on the same reset.

Configuration
- REQ-033 Macro ZWAIT_TIMEOUT_EN SHALL enable the timeout: the counter clears on entering SERV and increments each SERV cycle.
- REQ-034 With ZWAIT_TIMEOUT_EN, when the count reaches 2^TMO_W-1 the block SHALL load wait_rdata with 8'hFF, set timed_out and enter REL.
- REQ-035 timed_out SHALL clear on the next CAPT.
- REQ-036 Without ZWAIT_TIMEOUT_EN, no counter SHALL exist, timed_out SHALL read 0, and SERV SHALL be left only by RELEASE or reset.

Structure
- REQ-037 The command codes, the FSM state encoding and the idle value 8'hFF SHALL be placed in a shared package zwait_pkg.
- REQ-038 The timeout counter SHALL be a sub-module zwait_tmo, instantiated only under ZWAIT_TIMEOUT_EN.

Verification
- REQ-039 Read wait: spiint_n low, wrn=1, status=2'b01; SETDATA 8'h5A then RELEASE -> one wait_end pulse; wait_rdata=8'h5A; GETSTAT returns 8'h05.
- REQ-040 Write wait: zdata_in=8'hC3, wrn=0, status=2'b10; GETDATA -> rsp_data 8'hC3 one cycle after cmd_stb; RELEASE -> wait_end.
- REQ-041 RELEASE in IDLE -> no wait_end, cmd_err=1; the following GETSTAT returns 8'h00 and clears cmd_err.
- REQ-042 With ZWAIT_TIMEOUT_EN and TMO_W=4: no command for 15 SERV cycles -> wait_end; wait_rdata 8'hFF; GETSTAT bit4=1.
- REQ-043 rst_n pulsed low in SERV -> svc_irq 0 immediately, no wait_end ever, IDLE; spiint_n held low for 1 cycle after RELEASE -> no second capture.
